// File: rtl/instr_issue_queue_pkg.sv
// Shared decode constants and the issue-class type used by the issue queue
// and the ID stage.
package instr_issue_queue_pkg;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_SOLO   = 2'd2
    } instr_class_t;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_BLEZ     = 6'h06;
    localparam logic [5:0] OP_BGTZ     = 6'h07;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0a;
    localparam logic [5:0] OP_SLTIU    = 6'h0b;
    localparam logic [5:0] OP_ANDI     = 6'h0c;
    localparam logic [5:0] OP_ORI      = 6'h0d;
    localparam logic [5:0] OP_XORI     = 6'h0e;
    localparam logic [5:0] OP_LUI      = 6'h0f;
    localparam logic [5:0] OP_COP0     = 6'h10;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1c;
    localparam logic [5:0] OP_SPECIAL3 = 6'h1f;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LH       = 6'h21;
    localparam logic [5:0] OP_LWL      = 6'h22;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_LBU      = 6'h24;
    localparam logic [5:0] OP_LHU      = 6'h25;
    localparam logic [5:0] OP_LWR      = 6'h26;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SWL      = 6'h2a;
    localparam logic [5:0] OP_SW       = 6'h2b;
    localparam logic [5:0] OP_SWR      = 6'h2e;
    localparam logic [5:0] OP_CACHE    = 6'h2f;
    localparam logic [5:0] OP_LL       = 6'h30;
    localparam logic [5:0] OP_SC       = 6'h38;

    // SPECIAL function codes (instr[5:0])
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_MOVZ    = 6'h0a;
    localparam logic [5:0] FN_MOVN    = 6'h0b;
    localparam logic [5:0] FN_SYSCALL = 6'h0c;
    localparam logic [5:0] FN_BREAK   = 6'h0d;
    localparam logic [5:0] FN_SYNC    = 6'h0f;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1a;
    localparam logic [5:0] FN_DIVU    = 6'h1b;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2a;
    localparam logic [5:0] FN_SLTU    = 6'h2b;

endpackage

// File: rtl/instr_issue_queue_predecode.sv
// Combinational issue-class predecoder: one instance per issue slot.
module instr_predecode
    import instr_issue_queue_pkg::*;
(
    input  logic [31:0]  instr_i,
    output instr_class_t cls_o
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_fields;

    assign op            = instr_i[31:26];
    assign fn            = instr_i[5:0];
    assign unused_fields = ^instr_i[25:6];

    always_comb begin
        cls_o = CLS_SOLO;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_JR, FN_JALR:
                        cls_o = CLS_BRANCH;
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_MOVZ, FN_MOVN, FN_MFHI, FN_MFLO,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU:
                        cls_o = CLS_ALU;
                    default:
                        cls_o = CLS_SOLO;
                endcase
            end
            OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                cls_o = CLS_BRANCH;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
            OP_LUI, OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
            OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR, OP_LL, OP_SC:
                cls_o = CLS_ALU;
            // COP0, SPECIAL2/3, CACHE and unknown opcodes all serialize
            default:
                cls_o = CLS_SOLO;
        endcase
    end

endmodule

// File: rtl/instr_issue_queue.sv
// Circular instruction issue queue: multi-lane fetch in, dual/single issue
// out with branch/delay-slot pairing and serializing-instruction handling.
module instr_issue_queue
    import instr_issue_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush_i,
    input  logic [FETCH_W-1:0]        in_valid_i,
    input  logic [FETCH_W*32-1:0]     in_instr_i,
    input  logic [FETCH_W*32-1:0]     in_pc_i,
    output logic                      in_ready_o,
    output logic [ISSUE_W-1:0]        out_valid_o,
    output logic [ISSUE_W*32-1:0]     out_instr_o,
    output logic [ISSUE_W*32-1:0]     out_pc_o,
    input  logic                      out_ready_i,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] FETCH_C = CW'(FETCH_W);

    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] push_cnt, pop_cnt;
    logic          push_en;

    instr_class_t  slot_cls [ISSUE_W];
    logic [PW-1:0] slot_idx [ISSUE_W];

    assign in_ready_o = (DEPTH_C - count_q) >= FETCH_C;
    assign push_en    = in_ready_o && !flush_i;
    assign count_o    = count_q;

    for (genvar s = 0; s < ISSUE_W; s++) begin : g_slot
        assign slot_idx[s] = head_q + PW'(s);
        instr_predecode u_predecode (
            .instr_i (instr_mem_q[slot_idx[s]]),
            .cls_o   (slot_cls[s])
        );
        assign out_instr_o[s*32 +: 32] = instr_mem_q[slot_idx[s]];
        assign out_pc_o[s*32 +: 32]    = pc_mem_q[slot_idx[s]];
    end

    if (ISSUE_W == 1) begin : g_single
        logic unused_cls;
        assign unused_cls  = ^slot_cls[0];
        assign out_valid_o = (count_q != '0);
    end else begin : g_dual
        logic two_q;
        assign two_q = count_q >= CW'(2);
        always_comb begin
            out_valid_o = 2'b00;
            // A branch never leaves without its delay slot beside it
            if (slot_cls[0] == CLS_BRANCH) begin
                out_valid_o = {two_q, two_q};
            end else if (count_q != '0) begin
                out_valid_o[0] = 1'b1;
                out_valid_o[1] = two_q && (slot_cls[0] != CLS_SOLO)
                                 && (slot_cls[1] == CLS_ALU);
            end
        end
    end

    always_comb begin
        push_cnt = '0;
        pop_cnt  = '0;
        if (push_en) begin
            for (int l = 0; l < FETCH_W; l++) begin
                push_cnt = push_cnt + CW'(in_valid_i[l]);
            end
        end
        if (out_ready_i) begin
            for (int s = 0; s < ISSUE_W; s++) begin
                pop_cnt = pop_cnt + CW'(out_valid_o[s]);
            end
        end
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + pop_cnt[PW-1:0];
            tail_d  = tail_q + push_cnt[PW-1:0];
            count_d = count_q + push_cnt - pop_cnt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is data only; occupancy alone decides what is live
    always_ff @(posedge clk) begin
        if (push_en) begin
            for (int l = 0; l < FETCH_W; l++) begin
                if (in_valid_i[l]) begin
                    instr_mem_q[tail_q + PW'(l)] <= in_instr_i[l*32 +: 32];
                    pc_mem_q[tail_q + PW'(l)]    <= in_pc_i[l*32 +: 32];
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Scoreboard bench for instr_issue_queue (DEPTH=8, FETCH_W=2, ISSUE_W=2).
module tb_instr_issue_queue;

    localparam logic [31:0] I_ADDU  = 32'h00221821;
    localparam logic [31:0] I_OR    = 32'h00221825;
    localparam logic [31:0] I_NOP   = 32'h00000000;
    localparam logic [31:0] I_ADDIU = 32'h24010001;
    localparam logic [31:0] I_BEQ   = 32'h10220004;
    localparam logic [31:0] I_J     = 32'h08000040;
    localparam logic [31:0] I_MULT  = 32'h00220018;
    localparam logic [31:0] I_SYSC  = 32'h0000000c;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush_i;
    logic [1:0]  in_valid_i;
    logic [63:0] in_instr_i;
    logic [63:0] in_pc_i;
    logic        in_ready_o;
    logic [1:0]  out_valid_o;
    logic [63:0] out_instr_o;
    logic [63:0] out_pc_o;
    logic        out_ready_i;
    logic [3:0]  count_o;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] sb_instr [$];
    logic [31:0] sb_pc    [$];

    instr_issue_queue #(.DEPTH(8), .FETCH_W(2), .ISSUE_W(2)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_instr_i  (in_instr_i),
        .in_pc_i     (in_pc_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_instr_o (out_instr_o),
        .out_pc_o    (out_pc_o),
        .out_ready_i (out_ready_i),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // 0 = ALU, 1 = BRANCH, 2 = SOLO for the words this bench uses
    function automatic int tb_cls(input logic [31:0] w);
        case (w)
            I_BEQ, I_J:     return 1;
            I_MULT, I_SYSC: return 2;
            default:        return 0;
        endcase
    endfunction

    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1,
                         input logic rdy, input logic fl);
        in_valid_i  = v;
        in_instr_i  = {i1, i0};
        in_pc_i     = {p1, p0};
        out_ready_i = rdy;
        flush_i     = fl;
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(2'b00, I_NOP, 32'h0, I_NOP, 32'h0, rdy, 1'b0);
    endtask

    task automatic tick();
        int n;
        int c0;
        logic [1:0] ev;
        n  = sb_instr.size();
        ev = 2'b00;
        if (n >= 1) begin
            c0 = tb_cls(sb_instr[0]);
            if (c0 == 1) ev = (n >= 2) ? 2'b11 : 2'b00;
            else begin
                ev[0] = 1'b1;
                if (n >= 2 && c0 != 2 && tb_cls(sb_instr[1]) == 0) ev[1] = 1'b1;
            end
        end
        check("out_valid", 64'(out_valid_o), 64'(ev));
        check("count", 64'(count_o), 64'(n));
        check("in_ready", 64'(in_ready_o), 64'(n <= 6));
        if (flush_i) begin
            sb_instr.delete();
            sb_pc.delete();
        end else begin
            if (out_ready_i) begin
                for (int s = 0; s < 2; s++) begin
                    if (out_valid_o[s]) begin
                        if (sb_instr.size() == 0) check("pop_empty", 64'(out_valid_o[s]), 64'd0);
                        else begin
                            check($sformatf("issue_pc%0d", s), 64'(out_pc_o[s*32 +: 32]), 64'(sb_pc.pop_front()));
                            check($sformatf("issue_instr%0d", s), 64'(out_instr_o[s*32 +: 32]), 64'(sb_instr.pop_front()));
                        end
                    end
                end
            end
            if (in_ready_o) begin
                for (int l = 0; l < 2; l++) begin
                    if (in_valid_i[l]) begin
                        sb_instr.push_back(in_instr_i[l*32 +: 32]);
                        sb_pc.push_back(in_pc_i[l*32 +: 32]);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (count_o != 0 || sb_instr.size() != 0); k++) begin
            idle(1'b1);
            tick();
        end
        check("drain_count", 64'(count_o), 64'd0);
    endtask

    initial begin
        logic [31:0] pool [6];
        logic [31:0] pc;
        logic [31:0] wa, wb;
        int pushed;
        int lanes;
        pool = '{I_ADDU, I_OR, I_ADDIU, I_BEQ, I_MULT, I_J};

        resetn = 1'b0;
        idle(1'b0);
        #12;
        check("reset_count", 64'(count_o), 64'd0);
        check("reset_valid", 64'(out_valid_o), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        check("reset_ready", 64'(in_ready_o), 64'd1);

        // ADDU/OR pair dual-issues the cycle after being written
        drive(2'b11, I_ADDU, 32'h100, I_OR, 32'h104, 1'b1, 1'b0);
        check("pair_empty_valid", 64'(out_valid_o), 64'd0);
        tick();
        idle(1'b1);
        check("pair_valid", 64'(out_valid_o), 64'd3);
        tick();
        idle(1'b0);
        check("pair_count", 64'(count_o), 64'd0);
        tick();

        // Branch waits for its delay slot
        drive(2'b01, I_BEQ, 32'h200, I_NOP, 32'h0, 1'b1, 1'b0);
        tick();
        drive(2'b01, I_NOP, 32'h204, I_NOP, 32'h0, 1'b1, 1'b0);
        check("br_wait_valid", 64'(out_valid_o), 64'd0);
        tick();
        idle(1'b1);
        check("br_pair_valid", 64'(out_valid_o), 64'd3);
        check("br_pair_pc0", 64'(out_pc_o[31:0]), 64'h200);
        check("br_pair_pc1", 64'(out_pc_o[63:32]), 64'h204);
        tick();

        // SOLO after ALU: each issues alone
        drive(2'b11, I_ADDU, 32'h300, I_MULT, 32'h304, 1'b0, 1'b0);
        tick();
        idle(1'b1);
        check("solo_first_valid", 64'(out_valid_o), 64'd1);
        check("solo_first_pc", 64'(out_pc_o[31:0]), 64'h300);
        tick();
        idle(1'b1);
        check("solo_second_valid", 64'(out_valid_o), 64'd1);
        check("solo_second_pc", 64'(out_pc_o[31:0]), 64'h304);
        tick();

        // Fill to 7, blocked push, then pop one
        pc = 32'h400;
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, I_MULT, pc, I_MULT, pc + 4, 1'b0, 1'b0);
            tick();
            pc += 8;
        end
        drive(2'b01, I_MULT, pc, I_NOP, 32'h0, 1'b0, 1'b0);
        tick();
        pc += 4;
        drive(2'b01, I_ADDIU, 32'h4f0, I_NOP, 32'h0, 1'b0, 1'b0);
        check("full_count", 64'(count_o), 64'd7);
        check("full_ready", 64'(in_ready_o), 64'd0);
        tick();
        idle(1'b1);
        check("full_hold_count", 64'(count_o), 64'd7);
        check("full_pop_valid", 64'(out_valid_o), 64'd1);
        tick();
        idle(1'b0);
        check("after_pop_ready", 64'(in_ready_o), 64'd1);
        check("after_pop_count", 64'(count_o), 64'd6);
        tick();
        drain();

        // Flush beats simultaneous push and pop
        drive(2'b11, I_ADDIU, 32'h500, I_ADDIU, 32'h504, 1'b0, 1'b0);
        tick();
        drive(2'b11, I_ADDIU, 32'h508, I_ADDIU, 32'h50c, 1'b0, 1'b0);
        tick();
        drive(2'b01, I_ADDIU, 32'h510, I_NOP, 32'h0, 1'b0, 1'b0);
        tick();
        drive(2'b11, I_ADDU, 32'h514, I_OR, 32'h518, 1'b1, 1'b1);
        check("preflush_count", 64'(count_o), 64'd5);
        tick();
        idle(1'b0);
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_valid", 64'(out_valid_o), 64'd0);
        tick();

        // Asynchronous reset mid-burst discards everything
        drive(2'b11, I_ADDU, 32'h600, I_OR, 32'h604, 1'b0, 1'b0);
        tick();
        drive(2'b11, I_ADDU, 32'h608, I_OR, 32'h60c, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_count", 64'(count_o), 64'd0);
        check("midrst_valid", 64'(out_valid_o), 64'd0);
        sb_instr.delete();
        sb_pc.delete();
        idle(1'b0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        check("midrst_ready", 64'(in_ready_o), 64'd1);

        // Random traffic through several pointer wraps
        pc = 32'h1000;
        pushed = 0;
        for (int k = 0; k < 2000 && pushed < 24; k++) begin
            lanes = $urandom_range(0, 2);
            wa = pool[$urandom_range(0, 5)];
            wb = pool[$urandom_range(0, 5)];
            drive((lanes == 2) ? 2'b11 : (lanes == 1) ? 2'b01 : 2'b00,
                  wa, pc, wb, pc + 4, ($urandom_range(0, 3) != 0), 1'b0);
            if (in_ready_o && lanes != 0) begin
                pushed += lanes;
                pc += 32'(lanes * 4);
            end
            tick();
        end
        // Trailing ALU so a final branch still gets its delay slot
        for (int k = 0; k < 20 && !in_ready_o; k++) begin
            idle(1'b1);
            tick();
        end
        drive(2'b01, I_ADDU, pc, I_NOP, 32'h0, 1'b1, 1'b0);
        tick();
        drain();
        check("final_sb_empty", 64'(sb_instr.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
